// File: rtl/fir_tap_bank_ctrl.sv
// Shadow/active FIR coefficient bank with atomic swap on the decimated-rate strobe.
// Build option FIR_TAP_SYM_EN: symmetric writes (addr k also writes TAP_LEN-1-k).
module fir_tap_bank_ctrl #(
   parameter int TAP_LEN = 21,
   parameter int COEF_W  = 16,
   parameter int ADDR_W  = 5,
   parameter logic [TAP_LEN-1:0][COEF_W-1:0] DEFAULT_TAP = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic signed [COEF_W-1:0]  wr_data,
   input  logic                      commit_valid,
   output logic                      commit_ready,
   input  logic                      swap_strobe,
   output logic [TAP_LEN*COEF_W-1:0] tap,
   output logic                      swap_done,
   output logic                      busy,
   output logic                      addr_err,
   output logic [15:0]               swap_count
);

   // state    | meaning
   // ST_INIT  | just out of reset, handshakes held off for one cycle
   // ST_IDLE  | accepting coefficient writes and commits
   // ST_ARMED | commit pending, waiting for a later swap_strobe
   // ST_SWAP  | active bank updated this cycle, swap_done pulses
   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ARMED, ST_SWAP} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAP_LEN - 1);
   localparam logic [ADDR_W-1:0] MID_ADDR  = ADDR_W'((TAP_LEN - 1) / 2);

   state_t state, state_nxt;
   logic   swap_en;
   logic   wr_fire;
   logic   in_range;
   logic [TAP_LEN-1:0][COEF_W-1:0] shadow;
   logic [TAP_LEN-1:0][COEF_W-1:0] active;

`ifdef FIR_TAP_SYM_EN
   logic [ADDR_W-1:0] mirror_addr;
   assign mirror_addr = LAST_ADDR - wr_addr;
   assign in_range    = (wr_addr <= MID_ADDR);
`else
   assign in_range    = (wr_addr <= LAST_ADDR);
`endif

   assign wr_fire = wr_valid && wr_ready;
   assign tap     = active;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_INIT;
      else      state <= state_nxt;
   end

   // A strobe in the commit-accept cycle lands while still in IDLE, so it is ignored.
   always_comb begin
      state_nxt    = state;
      wr_ready     = 1'b0;
      commit_ready = 1'b0;
      busy         = 1'b0;
      swap_done    = 1'b0;
      swap_en      = 1'b0;
      case (state)
         ST_INIT: state_nxt = ST_IDLE;
         ST_IDLE: begin
            wr_ready     = 1'b1;
            commit_ready = 1'b1;
            if (commit_valid) state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            busy = 1'b1;
            if (swap_strobe) begin
               swap_en   = 1'b1;
               state_nxt = ST_SWAP;
            end
         end
         ST_SWAP: begin
            swap_done = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow     <= DEFAULT_TAP;
         active     <= DEFAULT_TAP;
         addr_err   <= 1'b0;
         swap_count <= 16'd0;
      end else begin
         if (wr_fire) begin
            if (in_range) begin
               shadow[wr_addr] <= wr_data;
`ifdef FIR_TAP_SYM_EN
               shadow[mirror_addr] <= wr_data;
`endif
            end else begin
               addr_err <= 1'b1;
            end
         end
         if (swap_en) begin
            active     <= shadow;
            swap_count <= swap_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fir_tap_bank_ctrl.sv
// Directed bench for fir_tap_bank_ctrl: ramp default bank, swap timing, address errors, reset cancel.
module tb_fir_tap_bank_ctrl;

   localparam int TAP_LEN = 21;
   localparam int COEF_W  = 16;
   localparam int ADDR_W  = 5;

   function automatic logic [TAP_LEN-1:0][COEF_W-1:0] make_ramp();
      logic [TAP_LEN-1:0][COEF_W-1:0] r;
      for (int i = 0; i < TAP_LEN; i++) r[i] = 16'(i);
      return r;
   endfunction

   localparam logic [TAP_LEN-1:0][COEF_W-1:0] RAMP = make_ramp();

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      wr_valid;
   logic                      wr_ready;
   logic [ADDR_W-1:0]         wr_addr;
   logic signed [COEF_W-1:0]  wr_data;
   logic                      commit_valid;
   logic                      commit_ready;
   logic                      swap_strobe;
   logic [TAP_LEN*COEF_W-1:0] tap;
   logic                      swap_done;
   logic                      busy;
   logic                      addr_err;
   logic [15:0]               swap_count;

   int total = 0;
   int bad   = 0;
   logic signed [COEF_W-1:0] exp_tap [TAP_LEN];

   fir_tap_bank_ctrl #(
      .TAP_LEN(TAP_LEN), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .DEFAULT_TAP(RAMP)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .swap_strobe(swap_strobe), .tap(tap), .swap_done(swap_done),
      .busy(busy), .addr_err(addr_err), .swap_count(swap_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [COEF_W-1:0] tap_at(input int i);
      return tap[i*COEF_W +: COEF_W];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < TAP_LEN; i++) exp_tap[i] = 16'(i);
   endtask

   task automatic model_write(input int k, input logic signed [COEF_W-1:0] d);
`ifdef FIR_TAP_SYM_EN
      if (k <= (TAP_LEN - 1) / 2) begin
         exp_tap[k] = d;
         exp_tap[TAP_LEN - 1 - k] = d;
      end
`else
      if (k < TAP_LEN) exp_tap[k] = d;
`endif
   endtask

   task automatic do_write(input int k, input logic signed [COEF_W-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(k);
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b want=0", wr_ready); end
      total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL reset_commit_ready got=%b want=0", commit_ready); end
      total++; if (swap_count !== 16'd0) begin bad++; $display("FAIL reset_swap_count got=%0d want=0", swap_count); end
      total++; if ({busy, swap_done, addr_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, swap_done, addr_err}); end
      for (int i = 0; i < TAP_LEN; i++) begin
         total++; if (tap_at(i) !== 16'(i)) begin bad++; $display("FAIL reset_tap[%0d] got=%0d want=%0d", i, tap_at(i), i); end
      end
      rst = 1'b1;
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL release_wr_ready_early got=%b want=0", wr_ready); end
      tick();
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL first_clk_wr_ready got=%b want=1", wr_ready); end
      total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL first_clk_commit_ready got=%b want=1", commit_ready); end
   endtask

   task automatic test_swap();
      do_write(10, 16'sd13107);
      model_write(10, 16'sd13107);
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL armed_commit_ready got=%b want=0", commit_ready); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL armed_wr_ready got=%b want=0", wr_ready); end
      for (int c = 0; c < 50; c++) begin
         total++; if (tap_at(10) !== 16'd10 || busy !== 1'b1 || swap_done !== 1'b0) begin
            bad++; $display("FAIL hold_cycle%0d tap10=%0d busy=%b done=%b want tap10=10 busy=1 done=0", c, tap_at(10), busy, swap_done);
         end
         tick();
      end
      swap_strobe = 1'b1;
      tick();
      swap_strobe = 1'b0;
      total++; if (tap_at(10) !== 16'd13107) begin bad++; $display("FAIL swap_tap10 got=%0d want=13107", tap_at(10)); end
      total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL swap_done_pulse got=%b want=1", swap_done); end
      total++; if (swap_count !== 16'd1) begin bad++; $display("FAIL swap_count1 got=%0d want=1", swap_count); end
      total++; if (wr_ready !== 1'b0 || commit_ready !== 1'b0) begin bad++; $display("FAIL swap_ready got=%b%b want=00", wr_ready, commit_ready); end
      tick();
      total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL swap_done_single got=%b want=0", swap_done); end
      total++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL back_idle wr_ready=%b busy=%b want 1/0", wr_ready, busy); end
   endtask

   task automatic test_coincident_strobe();
      do_write(0, 16'sd777);
      model_write(0, 16'sd777);
      commit_valid = 1'b1;
      swap_strobe  = 1'b1;
      tick();
      commit_valid = 1'b0;
      swap_strobe  = 1'b0;
      total++; if (busy !== 1'b1 || swap_done !== 1'b0) begin bad++; $display("FAIL coincident_ignored busy=%b done=%b want 1/0", busy, swap_done); end
      total++; if (tap_at(0) !== 16'd0) begin bad++; $display("FAIL coincident_tap0 got=%0d want=0", tap_at(0)); end
      for (int c = 0; c < 4; c++) tick();
      total++; if (swap_done !== 1'b0 || tap_at(0) !== 16'd0) begin bad++; $display("FAIL pre_strobe done=%b tap0=%0d want 0/0", swap_done, tap_at(0)); end
      swap_strobe = 1'b1;
      tick();
      swap_strobe = 1'b0;
      total++; if (swap_done !== 1'b1 || swap_count !== 16'd2) begin bad++; $display("FAIL second_strobe done=%b count=%0d want 1/2", swap_done, swap_count); end
      total++; if (tap_at(0) !== 16'd777) begin bad++; $display("FAIL second_strobe_tap0 got=%0d want=777", tap_at(0)); end
      tick();
   endtask

   task automatic test_addr_err();
      wr_valid = 1'b1;
      wr_addr  = 5'd25;
      wr_data  = 16'h1234;
      #1;
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL oor_handshake got=%b want=1", wr_ready); end
      tick();
      wr_valid = 1'b0;
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_addr_err got=%b want=1", addr_err); end
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      swap_strobe  = 1'b1;
      tick();
      swap_strobe  = 1'b0;
      total++; if (swap_count !== 16'd3) begin bad++; $display("FAIL oor_swap_count got=%0d want=3", swap_count); end
      for (int i = 0; i < TAP_LEN; i++) begin
         total++; if (tap_at(i) !== exp_tap[i]) begin bad++; $display("FAIL oor_tap[%0d] got=%0d want=%0d", i, $signed(tap_at(i)), exp_tap[i]); end
      end
      tick();
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL addr_err_sticky got=%b want=1", addr_err); end
   endtask

   task automatic test_reset_armed();
      do_write(0, -16'sd139);
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b want=1", busy); end
      rst = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < TAP_LEN; i++) begin
         total++; if (tap_at(i) !== exp_tap[i]) begin bad++; $display("FAIL async_reset_tap[%0d] got=%0d want=%0d", i, $signed(tap_at(i)), exp_tap[i]); end
      end
      total++; if (addr_err !== 1'b0 || swap_count !== 16'd0 || busy !== 1'b0) begin
         bad++; $display("FAIL async_reset_flags err=%b count=%0d busy=%b want 0/0/0", addr_err, swap_count, busy);
      end
      #2;
      rst = 1'b1;
      tick();
      swap_strobe = 1'b1;
      tick();
      swap_strobe = 1'b0;
      total++; if (swap_done !== 1'b0 || swap_count !== 16'd0 || tap_at(0) !== 16'd0) begin
         bad++; $display("FAIL cancelled_swap done=%b count=%0d tap0=%0d want 0/0/0", swap_done, swap_count, $signed(tap_at(0)));
      end
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      swap_strobe  = 1'b1;
      tick();
      swap_strobe  = 1'b0;
      total++; if (tap_at(0) !== 16'd0 || swap_count !== 16'd1) begin
         bad++; $display("FAIL shadow_reset tap0=%0d count=%0d want 0/1", $signed(tap_at(0)), swap_count);
      end
      tick();
   endtask

`ifdef FIR_TAP_SYM_EN
   task automatic test_sym();
      do_write(2, -16'sd416);
      model_write(2, -16'sd416);
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      swap_strobe  = 1'b1;
      tick();
      swap_strobe  = 1'b0;
      total++; if (tap_at(2) !== 16'hFE60 || tap_at(18) !== 16'hFE60) begin
         bad++; $display("FAIL sym_pair tap2=%0d tap18=%0d want -416/-416", $signed(tap_at(2)), $signed(tap_at(18)));
      end
      tick();
      do_write(15, 16'sd999);
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL sym_upper_err got=%b want=1", addr_err); end
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      swap_strobe  = 1'b1;
      tick();
      swap_strobe  = 1'b0;
      for (int i = 0; i < TAP_LEN; i++) begin
         total++; if (tap_at(i) !== exp_tap[i]) begin bad++; $display("FAIL sym_tap[%0d] got=%0d want=%0d", i, $signed(tap_at(i)), exp_tap[i]); end
      end
      tick();
   endtask
`endif

   initial begin
      rst          = 1'b0;
      wr_valid     = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      commit_valid = 1'b0;
      swap_strobe  = 1'b0;
      model_reset();
      test_reset();
      test_swap();
      test_coincident_strobe();
      test_addr_err();
      test_reset_armed();
`ifdef FIR_TAP_SYM_EN
      test_sym();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
